control_unit: RTL

- Multi-cycle FSM that drives every control input of the K&S data path.
- Consumes the data path's decoded_instruction and its four flag outputs.
- Produces the PC, IR, register-file, ALU, flag-register and memory-select strobes, plus the RAM write strobe and a halt indication.
- Adds a retired-instruction counter for bench and debug visibility.

---
 rtl/control_unit.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// k_and_s_pkg / control_unit
//
// Multi-cycle control FSM for the K&S data path. Every instruction goes
// through FETCH and DECODE. Everything except NOP then spends one execute
// cycle before it returns to FETCH. HALT parks the FSM until reset.
//
// Ports
//   clk                 system clock, rising edge
//   rst_n               asynchronous active-low reset
//   decoded_instruction opcode decoded from IR (sampled in DECODE only)
//   zero_op, neg_op     registered zero / negative flags
//   unsigned_overflow   registered carry-out flag
//   signed_overflow     registered signed-overflow flag (no branch uses it)
//   branch              PC loads instruction address instead of PC+1
//   pc_enable           PC update strobe
//   ir_enable           IR load strobe
//   addr_sel            1 = RAM address from instruction, 0 = from PC
//   c_sel               1 = register write data from ALU, 0 = from RAM
//   operation           ALU op: 00 OR, 01 ADD, 10 SUB, 11 AND
//   write_reg_enable    register-file write strobe
//   flags_reg_enable    flag-register load strobe
//   ram_write_enable    RAM write strobe
//   halt                processor stopped
//   instr_count         saturating retired-instruction count
// ---------------------------------------------------------------------------
package k_and_s_pkg;
  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_LOAD   = 4'd1,
    I_STORE  = 4'd2,
    I_MOVE   = 4'd3,
    I_ADD    = 4'd4,
    I_SUB    = 4'd5,
    I_AND    = 4'd6,
    I_OR     = 4'd7,
    I_BRANCH = 4'd8,
    I_BZERO  = 4'd9,
    I_BNEG   = 4'd10,
    I_BNNEG  = 4'd11,
    I_BOV    = 4'd12,
    I_BNOV   = 4'd13,
    I_HALT   = 4'd14
  } decoded_instruction_type;
endpackage

module control_unit
  import k_and_s_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt,
  output logic [CNT_WIDTH-1:0]    instr_count
);

  localparam logic [2:0] S_FETCH    = 3'd0;
  localparam logic [2:0] S_DECODE   = 3'd1;
  localparam logic [2:0] S_EX_LOAD  = 3'd2;
  localparam logic [2:0] S_EX_STORE = 3'd3;
  localparam logic [2:0] S_EX_MOVE  = 3'd4;
  localparam logic [2:0] S_EX_ALU   = 3'd5;
  localparam logic [2:0] S_EX_BR    = 3'd6;
  localparam logic [2:0] S_HALTED   = 3'd7;

  logic [2:0]              state, next_state;
  decoded_instruction_type instr_q;   // opcode captured in DECODE
  logic                    br_taken;
  logic                    retire;

  // The signed-overflow flag is part of the data-path interface, but no
  // branch condition looks at it.
  logic flags_unused;
  assign flags_unused = signed_overflow;

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (decoded_instruction)
          I_LOAD:                      next_state = S_EX_LOAD;
          I_STORE:                     next_state = S_EX_STORE;
          I_MOVE:                      next_state = S_EX_MOVE;
          I_ADD, I_SUB, I_AND, I_OR:   next_state = S_EX_ALU;
          I_BRANCH, I_BZERO, I_BNEG,
          I_BNNEG, I_BOV, I_BNOV:      next_state = S_EX_BR;
          I_HALT:                      next_state = S_HALTED;
          default:                     next_state = S_FETCH;  // NOP / unknown
        endcase
      end
      S_HALTED: next_state = S_HALTED;
      default:  next_state = S_FETCH;   // every execute state lasts one cycle
    endcase
  end

  // An instruction retires whenever we come back to FETCH from any other
  // state. HALTED never leaves, so HALT itself is never counted.
  assign retire = (state != S_FETCH) && (next_state == S_FETCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_FETCH;
      instr_q     <= I_NOP;
      instr_count <= '0;
    end else begin
      state <= next_state;
      if (state == S_DECODE)
        instr_q <= decoded_instruction;
      if (retire && (instr_count != {CNT_WIDTH{1'b1}}))
        instr_count <= instr_count + CNT_WIDTH'(1);
    end
  end

  // Branch condition, evaluated on the flags present in the EX_BR cycle
  always_comb begin
    br_taken = 1'b0;
    case (instr_q)
      I_BRANCH: br_taken = 1'b1;
      I_BZERO:  br_taken = zero_op;
      I_BNEG:   br_taken = neg_op;
      I_BNNEG:  br_taken = ~neg_op;
      I_BOV:    br_taken = unsigned_overflow;
      I_BNOV:   br_taken = ~unsigned_overflow;
      default:  br_taken = 1'b0;
    endcase
  end

  // Control decode. It is purely combinational from state (and from flags in
  // EX_BR), so asserting reset forces the FETCH values straight away.
  always_comb begin
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = 2'b00;
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
    case (state)
      S_FETCH: begin
        ir_enable = 1'b1;
        pc_enable = 1'b1;
      end
      S_EX_LOAD: begin
        addr_sel         = 1'b1;
        write_reg_enable = 1'b1;
      end
      S_EX_STORE: begin
        addr_sel         = 1'b1;
        ram_write_enable = 1'b1;
      end
      S_EX_MOVE: begin
        // The OR pass-through moves the register, and the flags are left alone.
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
      end
      S_EX_ALU: begin
        case (instr_q)
          I_ADD:   operation = 2'b01;
          I_SUB:   operation = 2'b10;
          I_AND:   operation = 2'b11;
          default: operation = 2'b00;
        endcase
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
        flags_reg_enable = 1'b1;
      end
      S_EX_BR: begin
        branch    = 1'b1;
        pc_enable = br_taken;
      end
      S_HALTED: halt = 1'b1;
      default: ;
    endcase
  end

endmodule
